// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, default XLEN and the IMEM response record.
package core_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             inst;
  } imem_resp_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and decode handshake.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int unsigned XLEN = core_pkg::DEFAULT_XLEN
) ();

  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_GNT;
  logic            IMEM_RVALID;
  logic [31:0]     IMEM_RDATA;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            INST_VALID;
  logic            INST_READY;
  logic [31:0]     INST;
  logic [XLEN-1:0] INST_PC;

  modport master (
    output IMEM_REQ, IMEM_ADDR, INST_VALID, INST, INST_PC,
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, INST_READY
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INST_VALID, INST, INST_PC,
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, INST_READY
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer. Flush wins over push and pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [WIDTH-1:0]       head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             pop_ok;

  assign empty  = (count_q == '0);
  assign pop_ok = pop & ~empty;
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  // Storage write; the credit rule upstream guarantees no push into a full buffer.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Decoupled instruction-fetch front end: credit-limited in-order IMEM requests, response
// buffering with PCs, and redirect flush with discard of stale in-flight responses.
// Optional macro FETCH_PERF_EN adds PERF_FETCHED / PERF_FLUSHED counters.
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] PERF_FETCHED,
  output logic [31:0] PERF_FLUSHED
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;
  logic            credit, req_acc, drop, push, pop;
  logic [XLEN-1:0] redirect_pc;
  logic            unused_redirect_lsbs;

  assign redirect_pc          = {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.REDIRECT_PC[1:0];

  // Buffered entries plus in-flight requests never exceed the buffer size.
  assign credit  = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign req_acc = bus.IMEM_REQ & bus.IMEM_GNT;
  assign drop    = bus.REDIRECT | (discard_q != '0);
  assign push    = bus.IMEM_RVALID & ~drop;
  assign pop     = ~fifo_empty & bus.INST_READY & ~bus.REDIRECT;

  assign bus.IMEM_REQ   = ~RESET & ~bus.REDIRECT & credit;
  assign bus.IMEM_ADDR  = fetch_pc_q;
  assign bus.INST_VALID = ~fifo_empty;
  assign bus.INST       = fifo_empty ? INST_NOP : fifo_head[31:0];
  assign bus.INST_PC    = fifo_empty ? fetch_pc_q : fifo_head[EW-1:32];

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data ({resp_pc_q, bus.IMEM_RDATA}),
    .pop       (pop),
    .flush     (bus.REDIRECT),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Next-state for PCs and the in-flight / discard counters; redirect has priority.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;

    case ({req_acc, bus.IMEM_RVALID})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (bus.REDIRECT) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // outstanding already includes responses pending discard, so after this cycle every
      // request still in flight is stale.
      discard_d  = outstanding_q - CW'(bus.IMEM_RVALID);
    end else begin
      if (req_acc) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)    resp_pc_d  = resp_pc_q + XLEN'(4);
      if (bus.IMEM_RVALID && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;

  // Count decode pops, and every instruction lost to a flush or a dropped response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      perf_flushed_q <= perf_flushed_q + (bus.REDIRECT ? 32'(fifo_count) : 32'd0)
                        + 32'(bus.IMEM_RVALID & drop);
    end
  end

  assign PERF_FETCHED = perf_fetched_q;
  assign PERF_FLUSHED = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector tables, hand-built redirect and stall
// sequences, an in-order IMEM model with programmable latency and a decode-side scoreboard.
module tb_fetch_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_stage #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .PERF_FETCHED (perf_fetched),
    .PERF_FLUSHED (perf_flushed)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int grants = 0;
  int pops   = 0;
  logic [31:0] exp_pc = 32'h0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl[$];

  // Instruction image: word i is "addi x(i+1), x0, i".
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    return (i << 20) | (((i + 32'd1) & 32'd31) << 7) | 32'h13;
  endfunction

  function automatic vec_t mk(input logic gnt, input logic ready, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.gnt = gnt; v.ready = ready; v.req = req; v.addr = addr;
    v.valid = valid; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: record grants and consumed responses mid-cycle, drive responses after the edge.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (bus.IMEM_RVALID && mq.size() > 0) mq.delete(0);
      if (bus.IMEM_REQ && bus.IMEM_GNT) begin
        mq.push_back('{due: cyc + lat, addr: bus.IMEM_ADDR});
        grants++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.IMEM_RVALID = 1'b1;
      bus.IMEM_RDATA  = mem_word(mq[0].addr);
    end else begin
      bus.IMEM_RVALID = 1'b0;
      bus.IMEM_RDATA  = 32'h0;
    end
  end

  // Decode-side scoreboard: accepted instructions must follow the current PC stream.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'h0;
    end else if (bus.REDIRECT) begin
      exp_pc = {bus.REDIRECT_PC[31:2], 2'b00};
    end else if (bus.INST_VALID && bus.INST_READY) begin
      check("stream_pc", bus.INST_PC, exp_pc);
      check("stream_inst", bus.INST, mem_word(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0, the first cycle with RESET low.
  task automatic do_reset(input int latency);
    rst             = 1'b1;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    bus.IMEM_GNT    = 1'b1;
    bus.INST_READY  = 1'b1;
    lat             = latency;
    grants          = 0;
    pops            = 0;
    adv();
    adv();
    @(negedge clk);
    check("rst.req", {31'b0, bus.IMEM_REQ}, 32'h0);
    check("rst.addr", bus.IMEM_ADDR, 32'h0);
    check("rst.valid", {31'b0, bus.INST_VALID}, 32'h0);
    check("rst.inst", bus.INST, INST_NOP);
    check("rst.pc", bus.INST_PC, 32'h0);
    adv();
    rst = 1'b0;
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      bus.IMEM_GNT   = tbl[i].gnt;
      bus.INST_READY = tbl[i].ready;
      @(negedge clk);
      check($sformatf("%s[%0d].req", name, i), {31'b0, bus.IMEM_REQ}, {31'b0, tbl[i].req});
      check($sformatf("%s[%0d].addr", name, i), bus.IMEM_ADDR, tbl[i].addr);
      check($sformatf("%s[%0d].valid", name, i), {31'b0, bus.INST_VALID},
            {31'b0, tbl[i].valid});
      check($sformatf("%s[%0d].pc", name, i), bus.INST_PC, tbl[i].pc);
      check($sformatf("%s[%0d].inst", name, i), bus.INST, tbl[i].inst);
      adv();
    end
  endtask

  initial begin
    bus.IMEM_GNT    = 1'b1;
    bus.INST_READY  = 1'b1;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'h0;

    // Streaming from reset with a 1-cycle memory.
    tbl.delete();
    tbl.push_back(mk(1, 1, 1, 32'h00, 0, 32'h00, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h04, 0, 32'h04, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h08, 1, 32'h00, 32'h0000_0093));
    tbl.push_back(mk(1, 1, 1, 32'h0C, 1, 32'h04, 32'h0010_0113));
    tbl.push_back(mk(1, 1, 1, 32'h10, 1, 32'h08, 32'h0020_0193));
    tbl.push_back(mk(1, 1, 1, 32'h14, 1, 32'h0C, 32'h0030_0213));
    do_reset(1);
    run_table("stream");

    // Grant withheld for 5 cycles: request address must hold at 0x8.
    tbl.delete();
    tbl.push_back(mk(1, 1, 1, 32'h00, 0, 32'h00, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h04, 0, 32'h04, INST_NOP));
    tbl.push_back(mk(0, 1, 1, 32'h08, 1, 32'h00, 32'h0000_0093));
    tbl.push_back(mk(0, 1, 1, 32'h08, 1, 32'h04, 32'h0010_0113));
    tbl.push_back(mk(0, 1, 1, 32'h08, 0, 32'h08, INST_NOP));
    tbl.push_back(mk(0, 1, 1, 32'h08, 0, 32'h08, INST_NOP));
    tbl.push_back(mk(0, 1, 1, 32'h08, 0, 32'h08, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h08, 0, 32'h08, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h0C, 0, 32'h0C, INST_NOP));
    tbl.push_back(mk(1, 1, 1, 32'h10, 1, 32'h08, 32'h0020_0193));
    do_reset(1);
    run_table("nognt");

    // Decode back-pressure: four credits, then no requests, then no lost words.
    do_reset(1);
    bus.INST_READY = 1'b0;
    repeat (9) begin
      @(negedge clk);
      adv();
    end
    @(negedge clk);
    check("bp.req", {31'b0, bus.IMEM_REQ}, 32'h0);
    check("bp.grants", grants, 32'd4);
    check("bp.valid", {31'b0, bus.INST_VALID}, 32'h1);
    check("bp.pc", bus.INST_PC, 32'h0);
    adv();
    bus.INST_READY = 1'b1;
    repeat (12) begin
      @(negedge clk);
      adv();
    end
    check("bp.pops", pops, 32'd12);

    // 3-cycle memory, three in flight, redirect to 0x100 coinciding with the first response.
    do_reset(3);
    adv(); adv(); adv();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h100;
    @(negedge clk);
    check("rd1.req", {31'b0, bus.IMEM_REQ}, 32'h0);
    adv();
    bus.REDIRECT = 1'b0;
    @(negedge clk);
    check("rd1.req_new", {31'b0, bus.IMEM_REQ}, 32'h1);
    check("rd1.addr", bus.IMEM_ADDR, 32'h100);
    for (int c = 5; c <= 7; c++) begin
      adv();
      @(negedge clk);
      check($sformatf("rd1.stale_c%0d", c), {31'b0, bus.INST_VALID}, 32'h0);
    end
    adv();
    @(negedge clk);
    check("rd1.valid", {31'b0, bus.INST_VALID}, 32'h1);
    check("rd1.pc", bus.INST_PC, 32'h100);
    check("rd1.inst", bus.INST, 32'h0400_0093);
`ifdef FETCH_PERF_EN
    check("rd1.perf_flushed", perf_flushed, 32'd3);
`endif
    repeat (4) adv();

    // Second redirect to 0x200 while discards from the first are still pending.
    do_reset(3);
    adv(); adv(); adv();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h100;
    adv();
    bus.REDIRECT = 1'b0;
    adv();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h200;
    @(negedge clk);
    check("rd2.req", {31'b0, bus.IMEM_REQ}, 32'h0);
    adv();
    bus.REDIRECT = 1'b0;
    @(negedge clk);
    check("rd2.addr", bus.IMEM_ADDR, 32'h200);
    check("rd2.stale_c6", {31'b0, bus.INST_VALID}, 32'h0);
    for (int c = 7; c <= 9; c++) begin
      adv();
      @(negedge clk);
      check($sformatf("rd2.stale_c%0d", c), {31'b0, bus.INST_VALID}, 32'h0);
    end
    adv();
    @(negedge clk);
    check("rd2.valid", {31'b0, bus.INST_VALID}, 32'h1);
    check("rd2.pc", bus.INST_PC, 32'h200);
    check("rd2.inst", bus.INST, 32'h0800_0093);
`ifdef FETCH_PERF_EN
    check("rd2.perf_flushed", perf_flushed, 32'd4);
`endif
    repeat (6) adv();

    // PC wrap at the top of the address space, and masking of redirect low bits.
    do_reset(1);
    adv(); adv();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'hFFFF_FFFC;
    adv();
    bus.REDIRECT = 1'b0;
    @(negedge clk);
    check("wrap.addr_top", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    check("wrap.req", {31'b0, bus.IMEM_REQ}, 32'h1);
    adv();
    @(negedge clk);
    check("wrap.addr_zero", bus.IMEM_ADDR, 32'h0);
    adv();
    @(negedge clk);
    check("wrap.valid", {31'b0, bus.INST_VALID}, 32'h1);
    check("wrap.pc", bus.INST_PC, 32'hFFFF_FFFC);
    adv();
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h103;
    adv();
    bus.REDIRECT = 1'b0;
    @(negedge clk);
    check("mask.addr", bus.IMEM_ADDR, 32'h100);
`ifdef FETCH_PERF_EN
    check("mask.perf_flushed", perf_flushed, 32'd4);
`endif
    repeat (5) adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
